// File: rtl/xbar_mxs.sv
// M x S req/ack crossbar: per-slave decode, arbiter and IDLE/BUSY grant FSM; XBAR_RR_EN selects round-robin over fixed priority.
// Latency: grant 1 cycle after req, ack/rdata returned combinationally; masters hold req until ack, decode errors ack 1 cycle later.
module xbar_mxs #(
    parameter int N = 32,
    parameter int M = 2,
    parameter int S = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   master_req,
    input  logic [M*N-1:0] master_addr,
    input  logic [M-1:0]   master_cmd,
    input  logic [M*N-1:0] master_wdata,
    output logic [M-1:0]   master_ack,
    output logic [M*N-1:0] master_rdata,
    output logic [S-1:0]   slave_req,
    output logic [S*N-1:0] slave_addr,
    output logic [S-1:0]   slave_cmd,
    output logic [S*N-1:0] slave_wdata,
    input  logic [S-1:0]   slave_ack,
    input  logic [S*N-1:0] slave_rdata,
    output logic [S*M-1:0] slave_grant
);

    localparam int SW = (S > 1) ? $clog2(S) : 1;
    localparam int MW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t         state_q [S];
    state_t         state_d [S];
    logic [M-1:0]   grant_q [S];
    logic [M-1:0]   grant_d [S];
    logic [M-1:0]   err_q;
    logic [M-1:0]   err_d;

    logic [SW-1:0]  sel [M];
    logic [M-1:0]   bad;
    logic [M-1:0]   busy_m;
    logic [M-1:0]   cand [S];
    logic [M-1:0]   pick [S];
    logic [MW-1:0]  win  [S];

`ifdef XBAR_RR_EN
    logic [MW-1:0]  ptr_q [S];
    logic [MW-1:0]  ptr_d [S];
    logic [M-1:0]   hi    [S];
    logic [MW-1:0]  gidx  [S];
`endif

    always_comb begin
        bad    = '0;
        err_d  = '0;
        busy_m = '0;
        for (int m = 0; m < M; m++) begin
            sel[m]   = master_addr[m*N+N-1 -: SW];
            bad[m]   = (32'(sel[m]) >= S);
            // One pulse per bad request: the held req in the ack cycle must not re-arm.
            err_d[m] = master_req[m] & bad[m] & ~err_q[m];
        end
        for (int s = 0; s < S; s++) begin
            busy_m = busy_m | grant_q[s];
        end
    end

    always_comb begin
        for (int s = 0; s < S; s++) begin
            state_d[s] = state_q[s];
            grant_d[s] = grant_q[s];
            for (int m = 0; m < M; m++) begin
                cand[s][m] = master_req[m] & ~bad[m] & ~busy_m[m] & (32'(sel[m]) == s);
            end
`ifdef XBAR_RR_EN
            ptr_d[s] = ptr_q[s];
            gidx[s]  = '0;
            for (int m = 0; m < M; m++) begin
                hi[s][m] = cand[s][m] & (m >= int'(ptr_q[s]));
                if (grant_q[s][m]) gidx[s] = MW'(m);
            end
            // Candidates at/after the pointer take precedence; otherwise wrap to the lowest.
            pick[s] = (|hi[s]) ? hi[s] : cand[s];
`else
            pick[s] = cand[s];
`endif
            win[s] = '0;
            for (int m = M - 1; m >= 0; m--) begin
                if (pick[s][m]) win[s] = MW'(m);
            end
            case (state_q[s])
                IDLE: begin
                    if (|pick[s]) begin
                        grant_d[s]         = '0;
                        grant_d[s][win[s]] = 1'b1;
                        state_d[s]         = BUSY;
                    end
                end
                BUSY: begin
                    if (slave_ack[s]) begin
                        grant_d[s] = '0;
                        state_d[s] = IDLE;
`ifdef XBAR_RR_EN
                        ptr_d[s] = (gidx[s] == MW'(M - 1)) ? '0 : gidx[s] + 1'b1;
`endif
                    end
                end
                default: begin
                    grant_d[s] = '0;
                    state_d[s] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
            for (int s = 0; s < S; s++) begin
                state_q[s] <= IDLE;
                grant_q[s] <= '0;
`ifdef XBAR_RR_EN
                ptr_q[s]   <= '0;
`endif
            end
        end else begin
            err_q <= err_d;
            for (int s = 0; s < S; s++) begin
                state_q[s] <= state_d[s];
                grant_q[s] <= grant_d[s];
`ifdef XBAR_RR_EN
                ptr_q[s]   <= ptr_d[s];
`endif
            end
        end
    end

    // Grants are zero in IDLE, so every mux below collapses to 0 for an idle slave.
    always_comb begin
        slave_req    = '0;
        slave_addr   = '0;
        slave_cmd    = '0;
        slave_wdata  = '0;
        slave_grant  = '0;
        master_ack   = err_q;
        master_rdata = '0;
        for (int s = 0; s < S; s++) begin
            slave_req[s]          = (state_q[s] == BUSY);
            slave_grant[s*M +: M] = grant_q[s];
            for (int m = 0; m < M; m++) begin
                if (grant_q[s][m]) begin
                    slave_addr[s*N +: N]  = slave_addr[s*N +: N] | master_addr[m*N +: N];
                    slave_cmd[s]          = slave_cmd[s] | master_cmd[m];
                    slave_wdata[s*N +: N] = slave_wdata[s*N +: N] | master_wdata[m*N +: N];
                end
                if (grant_q[s][m] & slave_ack[s]) begin
                    master_ack[m]          = 1'b1;
                    master_rdata[m*N +: N] = master_rdata[m*N +: N] | slave_rdata[s*N +: N];
                end
            end
        end
    end

endmodule

// File: tb/tb_xbar_mxs.sv
// Directed bench for xbar_mxs: a 2x2 instance for the main scenarios and a 2x3 instance for decode errors.
module tb_xbar_mxs;

    logic        clk;
    logic        rst;

    logic [1:0]  m_req, m_cmd, m_ack, s_req, s_cmd, s_ack;
    logic [63:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata, s_rdata;
    logic [3:0]  s_grant;

    logic [1:0]  t_mreq, t_mcmd, t_mack;
    logic [63:0] t_maddr, t_mwdata, t_mrdata;
    logic [2:0]  t_sreq, t_scmd, t_sack;
    logic [95:0] t_saddr, t_swdata, t_srdata;
    logic [5:0]  t_sgrant;

    int checks = 0;
    int failures = 0;

    xbar_mxs #(.N(32), .M(2), .S(2)) dut (
        .clk(clk), .rst(rst),
        .master_req(m_req), .master_addr(m_addr), .master_cmd(m_cmd), .master_wdata(m_wdata),
        .master_ack(m_ack), .master_rdata(m_rdata),
        .slave_req(s_req), .slave_addr(s_addr), .slave_cmd(s_cmd), .slave_wdata(s_wdata),
        .slave_ack(s_ack), .slave_rdata(s_rdata), .slave_grant(s_grant)
    );

    xbar_mxs #(.N(32), .M(2), .S(3)) dut3 (
        .clk(clk), .rst(rst),
        .master_req(t_mreq), .master_addr(t_maddr), .master_cmd(t_mcmd), .master_wdata(t_mwdata),
        .master_ack(t_mack), .master_rdata(t_mrdata),
        .slave_req(t_sreq), .slave_addr(t_saddr), .slave_cmd(t_scmd), .slave_wdata(t_swdata),
        .slave_ack(t_sack), .slave_rdata(t_srdata), .slave_grant(t_sgrant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        m_req = '0; m_addr = '0; m_cmd = '0; m_wdata = '0; s_ack = '0; s_rdata = '0;
        t_mreq = '0; t_maddr = '0; t_mcmd = '0; t_mwdata = '0; t_sack = '0; t_srdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_req = 2'($urandom); m_addr = {$urandom, $urandom}; m_cmd = 2'($urandom);
            m_wdata = {$urandom, $urandom}; s_ack = 2'($urandom); s_rdata = {$urandom, $urandom};
            t_mreq = 2'($urandom); t_maddr = {$urandom, $urandom}; t_sack = 3'($urandom);
            t_srdata = {$urandom, $urandom, $urandom};
            #1;
            checks++;
            if ({m_ack, m_rdata, s_req, s_addr, s_cmd, s_wdata, s_grant} !== '0) begin
                failures++;
                $display("FAIL reset_outputs got ack=%b sreq=%b grant=%b rdata=%h want all 0", m_ack, s_req, s_grant, m_rdata);
            end
            checks++;
            if ({t_mack, t_mrdata, t_sreq, t_saddr, t_scmd, t_swdata, t_sgrant} !== '0) begin
                failures++;
                $display("FAIL reset_outputs3 got ack=%b sreq=%b grant=%b want all 0", t_mack, t_sreq, t_sgrant);
            end
            cyc();
        end
        zero_inputs();
        #1;
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({m_ack, m_rdata, s_req, s_addr, s_cmd, s_wdata, s_grant} !== '0) begin
            failures++;
            $display("FAIL reset_release got ack=%b sreq=%b grant=%b want all 0", m_ack, s_req, s_grant);
        end
    endtask

    task automatic test_single_write();
        cyc();
        m_req = 2'b01; m_addr[31:0] = 32'h0000_0010; m_cmd = 2'b01; m_wdata[31:0] = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (s_req !== 2'b00) begin failures++; $display("FAIL single_no_early_req got=%b want=00", s_req); end
        cyc();
        checks++;
        if (s_req !== 2'b01) begin failures++; $display("FAIL single_sreq got=%b want=01", s_req); end
        checks++;
        if ({s_addr[31:0], s_cmd[0], s_wdata[31:0]} !== {32'h0000_0010, 1'b1, 32'hA5A5_A5A5}) begin
            failures++;
            $display("FAIL single_fields got addr=%h cmd=%b wdata=%h want 00000010 1 a5a5a5a5", s_addr[31:0], s_cmd[0], s_wdata[31:0]);
        end
        checks++;
        if (s_grant !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b want=0001", s_grant); end
        cyc();
        checks++;
        if (m_ack !== 2'b00) begin failures++; $display("FAIL single_no_early_ack got=%b want=00", m_ack); end
        cyc();
        s_ack = 2'b01; s_rdata[31:0] = 32'h0000_BEEF;
        #1;
        checks++;
        if ({m_ack, m_rdata[31:0]} !== {2'b01, 32'h0000_BEEF}) begin
            failures++;
            $display("FAIL single_ack got ack=%b rdata=%h want 01 0000beef", m_ack, m_rdata[31:0]);
        end
        cyc();
        zero_inputs();
        #1;
        checks++;
        if ({s_req, s_grant} !== 6'b0) begin failures++; $display("FAIL single_release got sreq=%b grant=%b want 0", s_req, s_grant); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_order [8];
        logic [1:0] w;
        int done0 = 0;
        int done1 = 0;
        int n = 0;
`ifdef XBAR_RR_EN
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
`endif
        m_addr = {32'h8000_0004, 32'h8000_0004};
        m_cmd = 2'b00;
        for (int c = 0; c < 60 && n < 8; c++) begin
            cyc();
            s_ack = 2'b00;
            m_req[0] = (done0 < 4);
            m_req[1] = (done1 < 4);
            #1;
            if (s_req[1]) begin
                w = s_grant[3:2];
                checks++;
                if (w !== exp_order[n]) begin
                    failures++;
                    $display("FAIL contention_order[%0d] got=%b want=%b", n, w, exp_order[n]);
                end
                s_ack[1] = 1'b1;
                s_rdata[63:32] = 32'(n);
                #1;
                checks++;
                if (m_ack !== w) begin
                    failures++;
                    $display("FAIL contention_ack[%0d] got=%b want=%b", n, m_ack, w);
                end
                if (w == 2'b01) done0++;
                else if (w == 2'b10) done1++;
                n++;
            end
        end
        checks++;
        if (n !== 8) begin failures++; $display("FAIL contention_count got=%0d want=8", n); end
        cyc();
        zero_inputs();
    endtask

    task automatic test_parallel();
        cyc();
        m_req = 2'b11; m_addr = {32'h8000_0040, 32'h0000_0020}; m_cmd = 2'b00;
        cyc();
        checks++;
        if ({s_req, s_grant} !== {2'b11, 4'b1001}) begin
            failures++;
            $display("FAIL parallel_grant got sreq=%b grant=%b want 11 1001", s_req, s_grant);
        end
        cyc();
        s_ack = 2'b11; s_rdata = {32'h2222_0000, 32'h1111_0000};
        #1;
        checks++;
        if ({m_ack, m_rdata} !== {2'b11, 32'h2222_0000, 32'h1111_0000}) begin
            failures++;
            $display("FAIL parallel_ack got ack=%b rdata=%h want 11 2222000011110000", m_ack, m_rdata);
        end
        cyc();
        zero_inputs();
        #1;
        checks++;
        if (s_req !== 2'b00) begin failures++; $display("FAIL parallel_idle got=%b want=00", s_req); end
    endtask

    task automatic test_reset_mid();
        cyc();
        m_req = 2'b01; m_addr[31:0] = 32'h0000_0004;
        cyc();
        checks++;
        if (s_req !== 2'b01) begin failures++; $display("FAIL rstmid_busy got=%b want=01", s_req); end
        rst = 1'b0;
        #1;
        checks++;
        if ({s_req, s_grant} !== 6'b0) begin
            failures++;
            $display("FAIL rstmid_async got sreq=%b grant=%b want 0", s_req, s_grant);
        end
        m_req = 2'b00;
        cyc();
        rst = 1'b1;
        m_req = 2'b10; m_addr[63:32] = 32'h0000_0008;
        cyc();
        checks++;
        if ({s_req, s_grant, s_addr[31:0]} !== {2'b01, 4'b0010, 32'h0000_0008}) begin
            failures++;
            $display("FAIL rstmid_regrant got sreq=%b grant=%b addr=%h want 01 0010 00000008", s_req, s_grant, s_addr[31:0]);
        end
        s_ack = 2'b01;
        #1;
        checks++;
        if (m_ack !== 2'b10) begin failures++; $display("FAIL rstmid_ack got=%b want=10", m_ack); end
        cyc();
        zero_inputs();
    endtask

    task automatic test_decode_error();
        cyc();
        t_mreq = 2'b10; t_maddr = {32'hC000_0000, 32'h0}; t_sack = 3'b111; t_srdata = '1;
        #1;
        checks++;
        if ({t_mack, t_sreq} !== 5'b0) begin
            failures++;
            $display("FAIL decerr_early got ack=%b sreq=%b want 0", t_mack, t_sreq);
        end
        cyc();
        checks++;
        if ({t_mack, t_mrdata} !== {2'b10, 64'h0}) begin
            failures++;
            $display("FAIL decerr_ack got ack=%b rdata=%h want 10 0", t_mack, t_mrdata);
        end
        checks++;
        if (t_sreq !== 3'b000) begin failures++; $display("FAIL decerr_sreq got=%b want=000", t_sreq); end
        cyc();
        t_mreq = 2'b00;
        #1;
        checks++;
        if ({t_mack, t_sreq} !== 5'b0) begin
            failures++;
            $display("FAIL decerr_single_pulse got ack=%b sreq=%b want 0", t_mack, t_sreq);
        end
        t_sack = 3'b000;
        cyc();
        t_mreq = 2'b01; t_maddr[31:0] = 32'h8000_0000;
        cyc();
        checks++;
        if ({t_sreq, t_sgrant} !== {3'b100, 6'b010000}) begin
            failures++;
            $display("FAIL s3_slave2_grant got sreq=%b grant=%b want 100 010000", t_sreq, t_sgrant);
        end
        t_sack = 3'b100; t_srdata = {32'h0000_CAFE, 64'h0};
        #1;
        checks++;
        if ({t_mack, t_mrdata[31:0]} !== {2'b01, 32'h0000_CAFE}) begin
            failures++;
            $display("FAIL s3_slave2_ack got ack=%b rdata=%h want 01 0000cafe", t_mack, t_mrdata[31:0]);
        end
        cyc();
        zero_inputs();
    endtask

    initial begin
        rst = 1'b0;
        zero_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_parallel();
        test_reset_mid();
        test_decode_error();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
